sfx_sequencer: RTL

Sound-effect sequencer that drives the square-wave synth's HALF_PERIOD/ENABLE inputs. It is the writer side of that interface. Game logic pulses one of four effect triggers. The block then plays a fixed multi-step note sequence from an internal table: each step sets a half-period and holds it for a set number of sample ticks, then ENABLE drops. It sits between the game FSM and the synth and shares the synth's SAMPLE_TRIGGER strobe.

---
 rtl/sfx_sequencer_if.sv | 29 ++
 rtl/sfx_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sfx_sequencer_if.sv
// Bus between the game logic / sample clock and the sound-effect sequencer.
// The master side raises effect triggers and supplies the sample strobe;
// the slave side (the sequencer) drives the synth half-period and enable.
interface sfx_sequencer_if;
  logic        sample_trigger;
  logic [3:0]  trigger;
  logic [15:0] half_period;
  logic        enable;
  logic        busy;
  logic [1:0]  effect_id;

  modport master (
    output sample_trigger,
    output trigger,
    input  half_period,
    input  enable,
    input  busy,
    input  effect_id
  );

  modport slave (
    input  sample_trigger,
    input  trigger,
    output half_period,
    output enable,
    output busy,
    output effect_id
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays a short fixed note sequence per effect by
// feeding half-period / enable to the square-wave synth. Each step holds its
// half-period for a set number of sample strobes. Higher effect indices
// preempt lower ones; an equal index restarts the current effect.
module sfx_sequencer #(
  parameter int DUR_WIDTH = 12,
  parameter int MAX_STEPS = 4
) (
  input logic           clk,
  input logic           reset,
  sfx_sequencer_if.slave bus
);

  localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  typedef struct packed {
    logic [15:0]          hp;
    logic [DUR_WIDTH-1:0] dur;
    logic                 last;
  } entry_t;

  state_t               state;
  logic [STEP_W-1:0]    step;
  logic [DUR_WIDTH-1:0] counter;
  logic [15:0]          half_period;
  logic                 enable;
  logic [1:0]           effect_id;

  logic [1:0]           cand;
  logic                 has_cand;
  logic                 accept;
  logic [STEP_W-1:0]    step_next;
  logic                 final_step;
  entry_t               start_entry;
  entry_t               cur_entry;
  entry_t               next_entry;

  function automatic entry_t mk(input int hp, input int dur, input logic last);
    entry_t e;
    e.hp   = 16'(hp);
    e.dur  = DUR_WIDTH'(dur);
    e.last = last;
    return e;
  endfunction

  // Effect table; entries outside a sequence read as a silent one-tick last step.
  // A zero duration is stretched to one tick so every step consumes a strobe.
  function automatic entry_t lookup(input logic [1:0] eff, input logic [STEP_W-1:0] stp);
    entry_t e;
    e = mk(0, 1, 1'b1);
    case (eff)
      2'd0: if (int'(stp) == 0) e = mk(100, 200, 1'b1);
      2'd1: begin
        if (int'(stp) == 0) e = mk(80, 100, 1'b0);
        else if (int'(stp) == 1) e = mk(60, 100, 1'b1);
      end
      2'd2: if (int'(stp) == 0) e = mk(150, 50, 1'b1);
      default: begin
        if (int'(stp) == 0) e = mk(200, 300, 1'b0);
        else if (int'(stp) == 1) e = mk(250, 300, 1'b0);
        else if (int'(stp) == 2) e = mk(300, 300, 1'b0);
        else if (int'(stp) == 3) e = mk(400, 600, 1'b1);
      end
    endcase
    if (e.dur == '0) e.dur = DUR_WIDTH'(1);
    return e;
  endfunction

  // Pick the highest requested effect and decide whether it may start now.
  always_comb begin
    cand     = 2'd0;
    has_cand = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.trigger[i]) begin
        cand     = 2'(i);
        has_cand = 1'b1;
      end
    end
    accept      = has_cand && ((state == IDLE) || (cand >= effect_id));
    step_next   = step + STEP_W'(1);
    start_entry = lookup(cand, '0);
    cur_entry   = lookup(effect_id, step);
    next_entry  = lookup(effect_id, step_next);
    final_step  = cur_entry.last || (int'(step) == MAX_STEPS - 1);
  end

  // Sequencer FSM: start/restart/preempt on acceptance, otherwise count strobes
  // through the steps and fall back to idle after the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      step        <= '0;
      counter     <= '0;
      half_period <= '0;
      enable      <= 1'b0;
      effect_id   <= 2'd0;
    end else if (accept) begin
      state       <= PLAY;
      step        <= '0;
      counter     <= start_entry.dur;
      half_period <= start_entry.hp;
      enable      <= 1'b1;
      effect_id   <= cand;
    end else if ((state == PLAY) && bus.sample_trigger) begin
      if (counter > DUR_WIDTH'(1)) begin
        counter <= counter - DUR_WIDTH'(1);
      end else if (!final_step) begin
        step        <= step_next;
        counter     <= next_entry.dur;
        half_period <= next_entry.hp;
      end else begin
        state  <= IDLE;
        enable <= 1'b0;
      end
    end
  end

  assign bus.half_period = half_period;
  assign bus.enable      = enable;
  assign bus.busy        = enable;
  assign bus.effect_id   = effect_id;

endmodule
